// File: rtl/mesi_cache_ctrl_pkg.sv
// Shared types for the L2 MESI controller: opcodes, line states, bus/L1 message
// encodings and the geometry helpers used to size tag and index fields.
package cache_pkg;

  typedef enum logic [3:0] {
    CMD_RD_D     = 4'd0,
    CMD_WR       = 4'd1,
    CMD_RD_I     = 4'd2,
    CMD_SNP_INV  = 4'd3,
    CMD_SNP_RD   = 4'd4,
    CMD_SNP_WR   = 4'd5,
    CMD_SNP_RWIM = 4'd6,
    CMD_CLEAR    = 4'd8,
    CMD_NOP      = 4'd9
  } cmd_e;

  typedef enum logic [1:0] {ST_I, ST_S, ST_E, ST_M} mesi_e;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0, BUS_READ = 3'd1, BUS_WRITE = 3'd2, BUS_INVALIDATE = 3'd3, BUS_RWIM = 3'd4
  } bus_op_e;

  typedef enum logic [1:0] {SN_NOHIT = 2'd0, SN_HIT = 2'd1, SN_HITM = 2'd2} snoop_e;

  typedef enum logic [2:0] {
    L1_NONE = 3'd0, L1_GETLINE = 3'd1, L1_SENDLINE = 3'd2, L1_INVALIDATELINE = 3'd3, L1_EVICTLINE = 3'd4
  } l2l1_e;

  // One queued output: either a bus operation or an L2->L1 message.
  typedef struct packed {
    logic       bus;
    logic [2:0] code;
  } msg_t;

  function automatic int idx_w(int c_size, int d_size, int a_size);
    return c_size - $clog2(a_size) - d_size;
  endfunction

  function automatic int tag_w(int i_size, int c_size, int d_size, int a_size);
    return i_size - idx_w(c_size, d_size, a_size) - d_size;
  endfunction

  function automatic msg_t bus_msg(bus_op_e op);
    return '{bus: 1'b1, code: op};
  endfunction

  function automatic msg_t l1_msg(l2l1_e m);
    return '{bus: 1'b0, code: m};
  endfunction

endpackage

// File: rtl/mesi_cache_ctrl_if.sv
// Command, bus, L1 and statistics signals of the MESI controller.
interface mesi_cache_ctrl_if #(parameter int i_size = 32);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd;
  logic [i_size-1:0] addr;
  logic [1:0]        snoop_in;
  logic [2:0]        bus_op_out;
  logic              bus_op_valid;
  logic [1:0]        snoop_result;
  logic [2:0]        l2_l1;
  logic              l2_l1_valid;
  logic              hit;
  logic              miss;
  logic              done;
  logic [31:0]       read_cnt;
  logic [31:0]       write_cnt;
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;

  modport master (
    output cmd_valid, cmd, addr, snoop_in,
    input  cmd_ready, bus_op_out, bus_op_valid, snoop_result, l2_l1, l2_l1_valid,
           hit, miss, done, read_cnt, write_cnt, hit_cnt, miss_cnt
  );

  modport slave (
    input  cmd_valid, cmd, addr, snoop_in,
    output cmd_ready, bus_op_out, bus_op_valid, snoop_result, l2_l1, l2_l1_valid,
           hit, miss, done, read_cnt, write_cnt, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/mesi_cache_ctrl_plru.sv
// Tree pseudo-LRU for one set: node bit 1 steers the victim walk to the upper half.
module plru_tree #(
  parameter int WAYS = 8
) (
  input  logic [WAYS-2:0]         bits_in,
  input  logic [$clog2(WAYS)-1:0] acc_way,
  output logic [$clog2(WAYS)-1:0] victim,
  output logic [WAYS-2:0]         bits_out
);
  localparam int LV = $clog2(WAYS);
  localparam int NW = (WAYS > 2) ? $clog2(WAYS - 1) : 1;

  always_comb begin
    int   node;
    logic b;
    node   = 0;
    b      = 1'b0;
    victim = '0;
    for (int l = 0; l < LV; l++) begin
      b      = bits_in[NW'(node)];
      victim = (victim << 1) | LV'(b);
      node   = 2 * node + 1 + int'(b);
    end
  end

  // On access, every node on the path is pointed away from the touched way.
  always_comb begin
    int            node;
    logic [LV-1:0] a;
    logic          dir;
    node     = 0;
    a        = acc_way;
    dir      = 1'b0;
    bits_out = bits_in;
    for (int l = 0; l < LV; l++) begin
      dir                  = a[LV-1];
      a                    = a << 1;
      bits_out[NW'(node)]  = ~dir;
      node                 = 2 * node + 1 + int'(dir);
    end
  end
endmodule

// File: rtl/mesi_cache_ctrl.sv
// L2 MESI sequencing controller: one command per transaction, tag/state lookup,
// then an ordered one-per-cycle stream of bus and L1 messages.
module mesi_cache_ctrl
  import cache_pkg::*;
#(
  parameter int i_size = 32,
  parameter int c_size = 24,
  parameter int d_size = 6,
  parameter int a_size = 8
) (
  input logic              clk,
  input logic              rst_n,
  mesi_cache_ctrl_if.slave bus
);
  localparam int IDX    = idx_w(c_size, d_size, a_size);
  localparam int TAG    = tag_w(i_size, c_size, d_size, a_size);
  localparam int SETS   = 1 << IDX;
  localparam int WW     = $clog2(a_size);
  localparam int MAXMSG = 5;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_EMIT, S_CLEAR, S_DONE} fsm_e;

  fsm_e                     cur, nxt;
  logic [3:0]               cmd_r;
  logic [IDX-1:0]           set_r, clr_idx;
  logic [TAG-1:0]           tag_r;
  msg_t [MAXMSG-1:0]        lst_r, lst;
  logic [2:0]               cnt_r, cnt, ptr_r;
  logic [WW-1:0]            fill_way_r;
  logic                     hit_r, miss_r;
  snoop_e                   snp_r;
  logic [31:0]              rd_c, wr_c, hit_c, miss_c;

  logic [TAG-1:0]           tag_mem  [SETS][a_size];
  mesi_e                    st_mem   [SETS][a_size];
  logic [a_size-2:0]        plru_mem [SETS];

  logic                     hit_any, inv_any;
  logic [WW-1:0]            hit_way, inv_way, plru_vict, vict_way, acc_way;
  logic [a_size-2:0]        plru_nxt;
  mesi_e                    hst, vst, nst;
  logic                     is_rd, is_wr, st_we, tag_we, plru_we, l_hit, l_miss;
  snoop_e                   l_snp;
  msg_t                     cur_msg;

  // Descending scan so the lowest-index match/invalid way wins.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = a_size - 1; w >= 0; w--) begin
      if (st_mem[set_r][WW'(w)] != ST_I && tag_mem[set_r][WW'(w)] == tag_r) begin
        hit_any = 1'b1;
        hit_way = WW'(w);
      end
      if (st_mem[set_r][WW'(w)] == ST_I) begin
        inv_any = 1'b1;
        inv_way = WW'(w);
      end
    end
  end

  assign vict_way = inv_any ? inv_way : plru_vict;
  assign acc_way  = hit_any ? hit_way : vict_way;
  assign hst      = st_mem[set_r][hit_way];
  assign vst      = st_mem[set_r][vict_way];
  assign is_rd    = (cmd_r == CMD_RD_D) || (cmd_r == CMD_RD_I);
  assign is_wr    = (cmd_r == CMD_WR);

  plru_tree #(.WAYS(a_size)) u_plru (
    .bits_in  (plru_mem[set_r]),
    .acc_way  (acc_way),
    .victim   (plru_vict),
    .bits_out (plru_nxt)
  );

  always_comb begin
    lst     = '0;
    cnt     = '0;
    nst     = ST_I;
    st_we   = 1'b0;
    tag_we  = 1'b0;
    plru_we = 1'b0;
    l_hit   = 1'b0;
    l_miss  = 1'b0;
    l_snp   = SN_NOHIT;
    // CPU miss: the victim must leave before the new line is requested.
    if ((is_rd || is_wr) && !hit_any) begin
      if (vst == ST_M) begin
        lst[cnt] = l1_msg(L1_GETLINE);   cnt = cnt + 3'd1;
        lst[cnt] = bus_msg(BUS_WRITE);   cnt = cnt + 3'd1;
        lst[cnt] = l1_msg(L1_EVICTLINE); cnt = cnt + 3'd1;
      end else if (vst != ST_I) begin
        lst[cnt] = l1_msg(L1_EVICTLINE); cnt = cnt + 3'd1;
      end
    end
    case (cmd_r)
      CMD_RD_D, CMD_RD_I: begin
        plru_we = 1'b1;
        if (hit_any) begin
          l_hit    = 1'b1;
          lst[cnt] = l1_msg(L1_SENDLINE); cnt = cnt + 3'd1;
        end else begin
          l_miss   = 1'b1;
          tag_we   = 1'b1;
          st_we    = 1'b1;
          nst      = ST_I;
          lst[cnt] = bus_msg(BUS_READ);   cnt = cnt + 3'd1;
          lst[cnt] = l1_msg(L1_SENDLINE); cnt = cnt + 3'd1;
        end
      end
      CMD_WR: begin
        plru_we = 1'b1;
        st_we   = 1'b1;
        nst     = ST_M;
        if (hit_any) begin
          l_hit = 1'b1;
          if (hst == ST_S) begin
            lst[cnt] = bus_msg(BUS_INVALIDATE); cnt = cnt + 3'd1;
          end
        end else begin
          l_miss   = 1'b1;
          tag_we   = 1'b1;
          lst[cnt] = bus_msg(BUS_RWIM);   cnt = cnt + 3'd1;
          lst[cnt] = l1_msg(L1_SENDLINE); cnt = cnt + 3'd1;
        end
      end
      CMD_SNP_INV: if (hit_any && hst == ST_S) begin
        st_we    = 1'b1;
        nst      = ST_I;
        l_snp    = SN_HIT;
        lst[cnt] = l1_msg(L1_INVALIDATELINE); cnt = cnt + 3'd1;
      end
      CMD_SNP_RD: if (hit_any) begin
        st_we = 1'b1;
        nst   = ST_S;
        l_snp = SN_HIT;
        if (hst == ST_M) begin
          l_snp    = SN_HITM;
          lst[cnt] = l1_msg(L1_GETLINE); cnt = cnt + 3'd1;
          lst[cnt] = bus_msg(BUS_WRITE); cnt = cnt + 3'd1;
        end
      end
      CMD_SNP_RWIM: if (hit_any) begin
        st_we = 1'b1;
        nst   = ST_I;
        l_snp = SN_HIT;
        if (hst == ST_M) begin
          l_snp    = SN_HITM;
          lst[cnt] = l1_msg(L1_GETLINE); cnt = cnt + 3'd1;
          lst[cnt] = bus_msg(BUS_WRITE); cnt = cnt + 3'd1;
        end
        lst[cnt] = l1_msg(L1_INVALIDATELINE); cnt = cnt + 3'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE: if (bus.cmd_valid) begin
        if (bus.cmd == CMD_CLEAR)  nxt = S_CLEAR;
        else if (bus.cmd <= 4'd6)  nxt = S_LOOKUP;
        else                       nxt = S_DONE;
      end
      S_LOOKUP: nxt = (cnt == 3'd0) ? S_DONE : S_EMIT;
      S_EMIT:   if (ptr_r == cnt_r - 3'd1) nxt = S_DONE;
      S_CLEAR:  if (clr_idx == IDX'(SETS - 1)) nxt = S_DONE;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  assign cur_msg          = lst_r[ptr_r];
  assign bus.cmd_ready    = (cur == S_IDLE);
  assign bus.done         = (cur == S_DONE);
  assign bus.hit          = (cur == S_DONE) & hit_r;
  assign bus.miss         = (cur == S_DONE) & miss_r;
  assign bus.snoop_result = (cur == S_DONE) ? snp_r : SN_NOHIT;
  assign bus.bus_op_valid = (cur == S_EMIT) & cur_msg.bus;
  assign bus.bus_op_out   = bus.bus_op_valid ? cur_msg.code : 3'd0;
  assign bus.l2_l1_valid  = (cur == S_EMIT) & ~cur_msg.bus;
  assign bus.l2_l1        = bus.l2_l1_valid ? cur_msg.code : 3'd0;
  assign bus.read_cnt     = rd_c;
  assign bus.write_cnt    = wr_c;
  assign bus.hit_cnt      = hit_c;
  assign bus.miss_cnt     = miss_c;

  always_ff @(posedge clk) begin
    if (cur == S_LOOKUP && tag_we) tag_mem[set_r][acc_way] <= tag_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= S_IDLE;
      cmd_r      <= '0;
      set_r      <= '0;
      tag_r      <= '0;
      lst_r      <= '0;
      cnt_r      <= '0;
      ptr_r      <= '0;
      fill_way_r <= '0;
      hit_r      <= 1'b0;
      miss_r     <= 1'b0;
      snp_r      <= SN_NOHIT;
      clr_idx    <= '0;
      rd_c       <= '0;
      wr_c       <= '0;
      hit_c      <= '0;
      miss_c     <= '0;
      for (int s = 0; s < SETS; s++) begin
        plru_mem[IDX'(s)] <= '0;
        for (int w = 0; w < a_size; w++) st_mem[IDX'(s)][WW'(w)] <= ST_I;
      end
    end else begin
      cur <= nxt;
      case (cur)
        S_IDLE: if (bus.cmd_valid) begin
          cmd_r   <= bus.cmd;
          set_r   <= bus.addr[d_size +: IDX];
          tag_r   <= bus.addr[d_size + IDX +: TAG];
          hit_r   <= 1'b0;
          miss_r  <= 1'b0;
          snp_r   <= SN_NOHIT;
          clr_idx <= '0;
        end
        S_LOOKUP: begin
          lst_r      <= lst;
          cnt_r      <= cnt;
          ptr_r      <= '0;
          fill_way_r <= acc_way;
          hit_r      <= l_hit;
          miss_r     <= l_miss;
          snp_r      <= l_snp;
          if (st_we)   st_mem[set_r][acc_way] <= nst;
          if (plru_we) plru_mem[set_r] <= plru_nxt;
          if (is_rd)   rd_c   <= rd_c + 32'd1;
          if (is_wr)   wr_c   <= wr_c + 32'd1;
          if (l_hit)   hit_c  <= hit_c + 32'd1;
          if (l_miss)  miss_c <= miss_c + 32'd1;
        end
        S_EMIT: begin
          ptr_r <= ptr_r + 3'd1;
          // The fill state depends on the other caches' answer to our READ.
          if (cur_msg.bus && cur_msg.code == BUS_READ)
            st_mem[set_r][fill_way_r] <= (bus.snoop_in == SN_NOHIT) ? ST_E : ST_S;
        end
        S_CLEAR: begin
          for (int w = 0; w < a_size; w++) st_mem[clr_idx][WW'(w)] <= ST_I;
          plru_mem[clr_idx] <= '0;
          clr_idx           <= clr_idx + 1'b1;
          rd_c              <= '0;
          wr_c              <= '0;
          hit_c             <= '0;
          miss_c            <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule
